// File: rtl/rst_clear_seq.sv
// Reset sequencer: merges hard/soft reset requests, stretches them and sweeps a RAM range with
// fill data before releasing hard reset. Define CLR_PATTERN_EN for address-xor-fill clear data.
module rst_clear_seq #(
    parameter int unsigned       ADDR_W     = 21,
    parameter int unsigned       DATA_W     = 8,
    parameter int unsigned       NUM_SRC    = 4,
    parameter int unsigned       STRETCH    = 16,
    parameter logic [DATA_W-1:0] FILL_VALUE = '0
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] req_hard,
    input  logic               req_soft,
    input  logic [ADDR_W-1:0]  clr_end,
    input  logic               mem_ready,
    output logic [ADDR_W-1:0]  clr_addr,
    output logic [DATA_W-1:0]  clr_data,
    output logic               clr_we,
    output logic               hard_reset_o,
    output logic               soft_reset_o,
    output logic               busy,
    output logic               done
);

    localparam int unsigned      CNT_W    = (STRETCH > 1) ? $clog2(STRETCH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH - 1);

    typedef enum logic [2:0] {StIdle, StHold, StClear, StRelease, StSoft} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   hold_cnt_q;
    logic [ADDR_W-1:0]  end_q;
    logic               soft_q;
    logic               hard_any;
    logic               soft_rise;
    logic               accept;

    assign hard_any  = |req_hard;
    assign soft_rise = req_soft & ~soft_q;
    assign accept    = clr_we & mem_ready;
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q      <= StHold;
            hold_cnt_q   <= '0;
            end_q        <= '0;
            soft_q       <= 1'b1;
            hard_reset_o <= 1'b1;
            soft_reset_o <= 1'b0;
            clr_we       <= 1'b0;
            clr_addr     <= '0;
            done         <= 1'b0;
        end else begin
            // Edge register tracks req_soft in every state so a request seen while busy is dropped
            soft_q <= req_soft;
            done   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (hard_any) begin
                        state_q      <= StHold;
                        hold_cnt_q   <= '0;
                        hard_reset_o <= 1'b1;
                    end else if (soft_rise) begin
                        state_q      <= StSoft;
                        hold_cnt_q   <= '0;
                        soft_reset_o <= 1'b1;
                    end
                end
                StHold: begin
                    if (hard_any) begin
                        hold_cnt_q <= '0;
                    end else if (hold_cnt_q == CNT_LAST) begin
                        state_q  <= StClear;
                        end_q    <= clr_end;
                        clr_addr <= '0;
                        clr_we   <= 1'b1;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                StClear: begin
                    if (hard_any) begin
                        state_q    <= StHold;
                        hold_cnt_q <= '0;
                        clr_addr   <= '0;
                        clr_we     <= 1'b0;
                    end else if (accept) begin
                        if (clr_addr == end_q) begin
                            state_q      <= StRelease;
                            clr_we       <= 1'b0;
                            clr_addr     <= '0;
                            hard_reset_o <= 1'b0;
                            done         <= 1'b1;
                        end else begin
                            clr_addr <= clr_addr + 1'b1;
                        end
                    end
                end
                StRelease: begin
                    state_q <= StIdle;
                end
                StSoft: begin
                    if (hard_any) begin
                        state_q      <= StHold;
                        hold_cnt_q   <= '0;
                        soft_reset_o <= 1'b0;
                        hard_reset_o <= 1'b1;
                    end else if (hold_cnt_q == CNT_LAST) begin
                        state_q      <= StIdle;
                        soft_reset_o <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StHold;
                end
            endcase
        end
    end

`ifdef CLR_PATTERN_EN
    logic [DATA_W-1:0] addr_ext;

    if (ADDR_W >= DATA_W) begin : g_addr_trunc
        assign addr_ext = clr_addr[DATA_W-1:0];
    end else begin : g_addr_zext
        assign addr_ext = {{(DATA_W - ADDR_W){1'b0}}, clr_addr};
    end

    assign clr_data = addr_ext ^ FILL_VALUE;
`else
    assign clr_data = FILL_VALUE;
`endif

endmodule

// File: tb/tb_rst_clear_seq.sv
// Bench for rst_clear_seq: randomized clears, stalls, restarts and soft resets checked against a
// simple sweep model (next address to accept, writes counted, cycle budgets).
module tb_rst_clear_seq;

    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned STRETCH = 4;
    localparam logic [7:0]  FILL    = 8'hA5;

    logic               clk_sys;
    logic               reset;
    logic [NUM_SRC-1:0] req_hard;
    logic               req_soft;
    logic [ADDR_W-1:0]  clr_end;
    logic               mem_ready;
    logic [ADDR_W-1:0]  clr_addr;
    logic [DATA_W-1:0]  clr_data;
    logic               clr_we;
    logic               hard_reset_o;
    logic               soft_reset_o;
    logic               busy;
    logic               done;

    int total;
    int bad;

    rst_clear_seq #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .NUM_SRC   (NUM_SRC),
        .STRETCH   (STRETCH),
        .FILL_VALUE(FILL)
    ) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .req_hard    (req_hard),
        .req_soft    (req_soft),
        .clr_end     (clr_end),
        .mem_ready   (mem_ready),
        .clr_addr    (clr_addr),
        .clr_data    (clr_data),
        .clr_we      (clr_we),
        .hard_reset_o(hard_reset_o),
        .soft_reset_o(soft_reset_o),
        .busy        (busy),
        .done        (done)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] exp_data(input int a);
        logic [7:0] v;
        v = 8'(a & 15);
`ifdef CLR_PATTERN_EN
        return FILL ^ v;
`else
        v = 8'h00;
        return FILL ^ v;
`endif
    endfunction

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            total++;
            if (busy !== 1'b0 || hard_reset_o !== 1'b0 || soft_reset_o !== 1'b0 ||
                clr_we !== 1'b0 || done !== 1'b0) begin
                bad++;
                $display("FAIL idle: busy=%b hard=%b soft=%b we=%b done=%b want all 0",
                         busy, hard_reset_o, soft_reset_o, clr_we, done);
            end
            step();
        end
    endtask

    // From IDLE: hold one hard source for hold_len cycles, leaving the DUT in HOLD with count 0.
    task automatic trigger_hard(input int src, input int hold_len);
        req_hard = 4'(1 << src);
        for (int i = 0; i < hold_len; i++) begin
            step();
            total++;
            if (hard_reset_o !== 1'b1 || clr_we !== 1'b0 || soft_reset_o !== 1'b0 ||
                busy !== 1'b1) begin
                bad++;
                $display("FAIL trigger_hold: hard=%b we=%b soft=%b busy=%b want 1 0 0 1",
                         hard_reset_o, clr_we, soft_reset_o, busy);
            end
        end
        req_hard = '0;
    endtask

    // Starting in the first HOLD cycle with no hard request: STRETCH hold cycles, then writes
    // to 0..end_v in order, then one done cycle, then IDLE.
    task automatic sweep(input int end_v, input int mode);
        int         nxt;
        int         k;
        int         guard;
        bit         fin;
        bit         rdy;
        logic [3:0] pat;
        pat   = 4'b1001;
        nxt   = 0;
        k     = 0;
        guard = 0;
        fin   = 1'b0;
        clr_end = 4'(end_v);
        for (int i = 0; i < STRETCH; i++) begin
            total++;
            if (hard_reset_o !== 1'b1 || clr_we !== 1'b0 || soft_reset_o !== 1'b0 ||
                busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL sweep_hold: i=%0d hard=%b we=%b soft=%b busy=%b done=%b want 1 0 0 1 0",
                         i, hard_reset_o, clr_we, soft_reset_o, busy, done);
            end
            step();
        end
        while (!fin && guard < 200) begin
            clr_end = 4'($urandom);
            total++;
            if (clr_we !== 1'b1 || clr_addr !== 4'(nxt) || clr_data !== exp_data(nxt) ||
                hard_reset_o !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL sweep_write: we=%b addr=%0d data=%h hard=%b done=%b want 1 %0d %h 1 0",
                         clr_we, clr_addr, clr_data, hard_reset_o, done, nxt, exp_data(nxt));
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = pat[k % 4];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            mem_ready = rdy;
            k++;
            if (rdy) begin
                if (nxt == end_v) fin = 1'b1;
                nxt++;
            end
            step();
            guard++;
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL sweep_budget: accepted=%0d want %0d within 200 cycles", nxt, end_v + 1);
        end
        total++;
        if (done !== 1'b1 || hard_reset_o !== 1'b0 || clr_we !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL sweep_release: done=%b hard=%b we=%b busy=%b want 1 0 0 1",
                     done, hard_reset_o, clr_we, busy);
        end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || hard_reset_o !== 1'b0 || clr_addr !== 4'd0) begin
            bad++;
            $display("FAIL sweep_idle: done=%b busy=%b hard=%b addr=%0d want 0 0 0 0",
                     done, busy, hard_reset_o, clr_addr);
        end
    endtask

    // From the first HOLD cycle: run an always-ready clear until clr_addr reaches target.
    task automatic walk_to(input int end_v, input int target);
        clr_end   = 4'(end_v);
        mem_ready = 1'b1;
        for (int i = 0; i < STRETCH; i++) step();
        for (int a = 0; a <= target; a++) begin
            total++;
            if (clr_we !== 1'b1 || clr_addr !== 4'(a)) begin
                bad++;
                $display("FAIL walk: we=%b addr=%0d want 1 %0d", clr_we, clr_addr, a);
            end
            if (a < target) step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step();
        total++;
        if (hard_reset_o !== 1'b1 || soft_reset_o !== 1'b0 || clr_we !== 1'b0 ||
            clr_addr !== 4'd0 || busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: hard=%b soft=%b we=%b addr=%0d busy=%b done=%b want 1 0 0 0 1 0",
                     hard_reset_o, soft_reset_o, clr_we, clr_addr, busy, done);
        end
    endtask

    task automatic test_power_up();
        int cyc;
        int writes;
        clr_end   = 4'hF;
        mem_ready = 1'b1;
        reset     = 1'b0;
        cyc       = 0;
        writes    = 0;
        while (done !== 1'b1 && cyc < 100) begin
            if (clr_we === 1'b1) begin
                total++;
                if (clr_addr !== 4'(writes) || clr_data !== exp_data(writes) ||
                    (writes == 0 && cyc != STRETCH)) begin
                    bad++;
                    $display("FAIL power_up_write: cyc=%0d addr=%0d data=%h want %0d %h",
                             cyc, clr_addr, clr_data, writes, exp_data(writes));
                end
                writes++;
            end
            step();
            cyc++;
        end
        total++;
        if (cyc != 20 || writes != 16 || hard_reset_o !== 1'b0) begin
            bad++;
            $display("FAIL power_up_timing: done_cycle=%0d writes=%0d hard=%b want 20 16 0",
                     cyc, writes, hard_reset_o);
        end
        step();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL power_up_done_pulse: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_stall();
        trigger_hard(2, 1);
        sweep(15, 1);
        trigger_hard(1, 3);
        sweep(7, 1);
    endtask

    task automatic test_hard_restart();
        trigger_hard(0, 2);
        walk_to(15, 7);
        req_hard = 4'b0100;
        step();
        total++;
        if (clr_we !== 1'b0 || hard_reset_o !== 1'b1 || busy !== 1'b1 || clr_addr !== 4'd0) begin
            bad++;
            $display("FAIL hard_restart: we=%b hard=%b busy=%b addr=%0d want 0 1 1 0",
                     clr_we, hard_reset_o, busy, clr_addr);
        end
        req_hard = '0;
        sweep(15, 2);
    endtask

    task automatic test_soft();
        req_soft = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            total++;
            if (soft_reset_o !== 1'(i < STRETCH) || busy !== 1'(i < STRETCH) ||
                clr_we !== 1'b0 || hard_reset_o !== 1'b0) begin
                bad++;
                $display("FAIL soft_pulse: i=%0d soft=%b busy=%b we=%b hard=%b want %0d %0d 0 0",
                         i, soft_reset_o, busy, clr_we, hard_reset_o, i < STRETCH, i < STRETCH);
            end
        end
        req_soft = 1'b0;
        step();
        req_soft = 1'b1;
        for (int i = 0; i <= STRETCH; i++) begin
            step();
            total++;
            if (soft_reset_o !== 1'(i < STRETCH)) begin
                bad++;
                $display("FAIL soft_retrigger: i=%0d soft=%b want %0d", i, soft_reset_o, i < STRETCH);
            end
        end
        req_soft = 1'b0;
        step();
    endtask

    task automatic test_escalate();
        req_soft = 1'b1;
        step();
        step();
        total++;
        if (soft_reset_o !== 1'b1) begin
            bad++;
            $display("FAIL escalate_soft: soft=%b want 1", soft_reset_o);
        end
        req_hard = 4'b0001;
        step();
        total++;
        if (soft_reset_o !== 1'b0 || hard_reset_o !== 1'b1 || clr_we !== 1'b0) begin
            bad++;
            $display("FAIL escalate_swap: soft=%b hard=%b we=%b want 0 1 0",
                     soft_reset_o, hard_reset_o, clr_we);
        end
        req_hard = '0;
        req_soft = 1'b0;
        sweep(3, 0);
    endtask

    task automatic test_simultaneous();
        req_soft = 1'b0;
        step();
        req_soft = 1'b1;
        req_hard = 4'b1000;
        step();
        total++;
        if (hard_reset_o !== 1'b1 || soft_reset_o !== 1'b0) begin
            bad++;
            $display("FAIL hard_wins: hard=%b soft=%b want 1 0", hard_reset_o, soft_reset_o);
        end
        req_hard = '0;
        sweep(int'($urandom_range(0, 15)), 2);
        idle_cycles(5);
        req_soft = 1'b0;
        step();
    endtask

    task automatic test_mid_reset();
        trigger_hard(1, 1);
        walk_to(15, 5);
        reset = 1'b1;
        step();
        total++;
        if (hard_reset_o !== 1'b1 || clr_we !== 1'b0 || clr_addr !== 4'd0 || busy !== 1'b1 ||
            done !== 1'b0 || soft_reset_o !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: hard=%b we=%b addr=%0d busy=%b done=%b soft=%b want 1 0 0 1 0 0",
                     hard_reset_o, clr_we, clr_addr, busy, done, soft_reset_o);
        end
        step();
        reset = 1'b0;
        sweep(9, 2);
    endtask

    task automatic test_random();
        int end_v;
        for (int it = 0; it < 8; it++) begin
            idle_cycles(int'($urandom_range(1, 3)));
            trigger_hard(int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
            if (it == 0) end_v = 0;
            else if (it == 1) end_v = 15;
            else end_v = int'($urandom_range(0, 15));
            sweep(end_v, int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        req_hard  = '0;
        req_soft  = 1'b0;
        clr_end   = '0;
        mem_ready = 1'b0;
        test_reset();
        test_power_up();
        test_stall();
        test_hard_restart();
        test_soft();
        test_escalate();
        test_simultaneous();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
